// File: rtl/control_sequencer_pkg.sv
// control_defs: shared constants for the hardwired control sequencer.
//   - 5-bit opcode constants as seen in ir[31:27]
//   - 4-bit state encoding (IDLE = 0)
//   - opcode-class codes produced by op_classifier
package control_defs;

  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHRA = 5'd6;
  localparam logic [4:0] OP_SHL  = 5'd7;
  localparam logic [4:0] OP_ROR  = 5'd8;
  localparam logic [4:0] OP_ROL  = 5'd9;
  localparam logic [4:0] OP_AND  = 5'd10;
  localparam logic [4:0] OP_OR   = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StT0   = 4'd1,
    StT1   = 4'd2,
    StT2   = 4'd3,
    StT3   = 4'd4,
    StT4   = 4'd5,
    StT5   = 4'd6,
    StT6   = 4'd7,
    StHalt = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_BINARY  = 3'd0,
    CLS_UNARY   = 3'd1,
    CLS_MULDIV  = 3'd2,
    CLS_NOP     = 3'd3,
    CLS_HALT    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_e;

endpackage

// File: rtl/control_sequencer_op_classifier.sv
// op_classifier: combinational map from a 5-bit opcode to its execution class.
// Ports:
//   opcode   in  5  ir[31:27]
//   op_class out    class code (control_defs::op_class_e)
// Build option MUL_DIV_EN: when undefined, MUL and DIV classify as illegal.
module op_classifier
  import control_defs::*;
(
  input  logic [4:0] opcode,
  output op_class_e  op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:             op_class = CLS_BINARY;
      OP_NEG, OP_NOT:                            op_class = CLS_UNARY;
`ifdef MUL_DIV_EN
      OP_MUL, OP_DIV:                            op_class = CLS_MULDIV;
`endif
      OP_NOP:                                    op_class = CLS_NOP;
      OP_HALT:                                   op_class = CLS_HALT;
      default:                                   op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM driving the bus-based datapath control strobes through
// fetch (T0-T2) and register-to-register execute (T3-T6).
// Ports:
//   clk, clr (async active-high), start (pulse, honoured in IDLE/HALT), ir[31:0]
//   bus sources: PCout, Zlowout, ZHighout, MDRout
//   loads: MARin, PCin, MDRin, IRin, Yin, Zin (ZHI+ZLO), HIin, LOin
//   misc: IncPC, Read, Gra, Grb, Grc, Rin, Rout, operation[4:0], run, illegal (sticky)
// Build option MUL_DIV_EN: enables the MUL/DIV sequence (T5 LO, T6 HI); when undefined,
// MUL/DIV are illegal, T6 is unused and HIin/LOin/ZHighout stay 0.
module control_sequencer
  import control_defs::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        Zlowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  operation,
  output logic        run,
  output logic        illegal
);

  state_e    state_q, state_d;
  op_class_e op_class;
  logic      illegal_q;
  logic      start_ok;
  logic [4:0] opcode;

  assign opcode = ir[31:27];

  // Register fields are decoded by the datapath, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir[26:0];

  op_classifier u_op_classifier (
    .opcode   (opcode),
    .op_class (op_class)
  );

  assign start_ok = start && (state_q == StIdle || state_q == StHalt);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= StIdle;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StT3 && op_class == CLS_ILLEGAL) begin
        illegal_q <= 1'b1;
      end else if (start_ok) begin
        illegal_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StHalt: if (start) state_d = StT0;
      StT0: state_d = StT1;
      StT1: state_d = StT2;
      StT2: state_d = StT3;
      StT3: begin
        case (op_class)
          CLS_BINARY, CLS_UNARY, CLS_MULDIV: state_d = StT4;
          CLS_NOP:                           state_d = StT0;
          default:                           state_d = StHalt;
        endcase
      end
      StT4: state_d = (op_class == CLS_UNARY) ? StT0 : StT5;
`ifdef MUL_DIV_EN
      StT5: state_d = (op_class == CLS_MULDIV) ? StT6 : StT0;
      StT6: state_d = StT0;
`else
      StT5: state_d = StT0;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    HIin = 1'b0; LOin = 1'b0; IncPC = 1'b0; Read = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    operation = 5'd0;
    run = 1'b0;
    case (state_q)
      StT0: begin
        run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      StT1: begin
        run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      StT2: begin
        run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      StT3: begin
        run = 1'b1;
        if (op_class == CLS_BINARY || op_class == CLS_MULDIV) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (op_class == CLS_UNARY) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = opcode;
        end
      end
      StT4: begin
        run = 1'b1;
        if (op_class == CLS_UNARY) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (op_class == CLS_BINARY || op_class == CLS_MULDIV) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = opcode;
        end
      end
      StT5: begin
        run = 1'b1;
        if (op_class == CLS_BINARY) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
`ifdef MUL_DIV_EN
        else if (op_class == CLS_MULDIV) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end
`endif
      end
`ifdef MUL_DIV_EN
      StT6: begin
        run = 1'b1; ZHighout = 1'b1; HIin = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk, clr, start;
  logic [31:0] ir;
  logic PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin;
  logic HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, run, illegal;
  logic [4:0] operation;

  control_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .ir(ir),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .operation(operation), .run(run), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation word: {19 strobes, operation, run, illegal}
  logic [25:0] obs;
  assign obs = {PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin,
                HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, operation, run, illegal};

  localparam logic [18:0] S_PCOUT = 19'h40000, S_ZLO = 19'h20000, S_ZHI = 19'h10000;
  localparam logic [18:0] S_MDROUT = 19'h08000, S_MARIN = 19'h04000, S_PCIN = 19'h02000;
  localparam logic [18:0] S_MDRIN = 19'h01000, S_IRIN = 19'h00800, S_YIN = 19'h00400;
  localparam logic [18:0] S_ZIN = 19'h00200, S_HIIN = 19'h00100, S_LOIN = 19'h00080;
  localparam logic [18:0] S_INCPC = 19'h00040, S_READ = 19'h00020, S_GRA = 19'h00010;
  localparam logic [18:0] S_GRB = 19'h00008, S_GRC = 19'h00004, S_RIN = 19'h00002;
  localparam logic [18:0] S_ROUT = 19'h00001;

  localparam logic [31:0] IR_ADD = 32'h18918000, IR_NOT = 32'h90900000;
  localparam logic [31:0] IR_MUL = 32'h78118000, IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_NOP = 32'hD0000000, IR_BAD = 32'hF8000000;

  int vec_cnt = 0;
  int miss_cnt = 0;
  logic [25:0] exp_q [$];

  function automatic logic [25:0] w(logic [18:0] s, logic [4:0] op, logic r, logic il);
    return {s, op, r, il};
  endfunction

  function automatic logic [25:0] w_t0();  return w(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 5'd0, 1'b1, 1'b0); endfunction
  function automatic logic [25:0] w_t1();  return w(S_ZLO | S_PCIN | S_READ | S_MDRIN, 5'd0, 1'b1, 1'b0); endfunction
  function automatic logic [25:0] w_t2();  return w(S_MDROUT | S_IRIN, 5'd0, 1'b1, 1'b0); endfunction
  function automatic logic [25:0] w_zero(); return 26'd0; endfunction

  task automatic do_clear();
    @(negedge clk); clr = 1'b1; start = 1'b0;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic push_fetch();
    exp_q.delete();
    exp_q.push_back(w_t0()); exp_q.push_back(w_t1()); exp_q.push_back(w_t2());
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; ir = IR_ADD;
    #1;
    vec_cnt++;
    if (obs !== w_zero()) begin
      $display("FAIL reset_initial: got %h want %h", obs, w_zero()); miss_cnt++;
    end
    @(negedge clk); clr = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    vec_cnt++;
    if (obs !== w_t0()) begin
      $display("FAIL reset_start_t0: got %h want %h", obs, w_t0()); miss_cnt++;
    end
    @(negedge clk); @(negedge clk);
    vec_cnt++;
    if (obs !== w_t2()) begin
      $display("FAIL reset_t2: got %h want %h", obs, w_t2()); miss_cnt++;
    end
    #2 clr = 1'b1;
    #1;
    vec_cnt++;
    if (obs !== w_zero()) begin
      $display("FAIL reset_async_midfetch: got %h want %h", obs, w_zero()); miss_cnt++;
    end
    // clr and start together: clr wins
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    vec_cnt++;
    if (obs !== w_zero()) begin
      $display("FAIL reset_clr_beats_start: got %h want %h", obs, w_zero()); miss_cnt++;
    end
    clr = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (obs !== w_zero()) begin
      $display("FAIL reset_idle_hold: got %h want %h", obs, w_zero()); miss_cnt++;
    end
  endtask

  task automatic test_add();
    do_clear(); ir = IR_ADD;
    push_fetch();
    exp_q.push_back(w(S_GRB | S_ROUT | S_YIN, 5'd0, 1'b1, 1'b0));
    exp_q.push_back(w(S_GRC | S_ROUT | S_ZIN, 5'd3, 1'b1, 1'b0));
    exp_q.push_back(w(S_ZLO | S_GRA | S_RIN, 5'd0, 1'b1, 1'b0));
    exp_q.push_back(w_t0());
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      vec_cnt++;
      if (obs !== exp_q[i]) begin
        $display("FAIL add cyc%0d: got %h want %h", i, obs, exp_q[i]); miss_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_not();
    do_clear(); ir = IR_NOT;
    push_fetch();
    exp_q.push_back(w(S_GRB | S_ROUT | S_ZIN, 5'd18, 1'b1, 1'b0));
    exp_q.push_back(w(S_ZLO | S_GRA | S_RIN, 5'd0, 1'b1, 1'b0));
    exp_q.push_back(w_t0());
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      vec_cnt++;
      if (obs !== exp_q[i]) begin
        $display("FAIL not cyc%0d: got %h want %h", i, obs, exp_q[i]); miss_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mul();
    do_clear(); ir = IR_MUL;
    push_fetch();
`ifdef MUL_DIV_EN
    exp_q.push_back(w(S_GRB | S_ROUT | S_YIN, 5'd0, 1'b1, 1'b0));
    exp_q.push_back(w(S_GRC | S_ROUT | S_ZIN, 5'd15, 1'b1, 1'b0));
    exp_q.push_back(w(S_ZLO | S_LOIN, 5'd0, 1'b1, 1'b0));
    exp_q.push_back(w(S_ZHI | S_HIIN, 5'd0, 1'b1, 1'b0));
    exp_q.push_back(w_t0());
`else
    exp_q.push_back(w(19'd0, 5'd0, 1'b1, 1'b0));
    exp_q.push_back(w(19'd0, 5'd0, 1'b0, 1'b1));
    exp_q.push_back(w(19'd0, 5'd0, 1'b0, 1'b1));
`endif
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      vec_cnt++;
      if (obs !== exp_q[i]) begin
        $display("FAIL mul cyc%0d: got %h want %h", i, obs, exp_q[i]); miss_cnt++;
      end
      @(negedge clk);
    end
  endtask

  // NOP is 4 cycles; a start pulse during T1 must be ignored.
  task automatic test_nop_start_ignored();
    do_clear(); ir = IR_NOP;
    push_fetch();
    exp_q.push_back(w(19'd0, 5'd0, 1'b1, 1'b0));
    exp_q.push_back(w_t0());
    exp_q.push_back(w_t1());
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      vec_cnt++;
      if (obs !== exp_q[i]) begin
        $display("FAIL nop cyc%0d: got %h want %h", i, obs, exp_q[i]); miss_cnt++;
      end
      start = (i == 1);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_halt();
    do_clear(); ir = IR_HALT;
    push_fetch();
    exp_q.push_back(w(19'd0, 5'd0, 1'b1, 1'b0));
    for (int k = 0; k < 20; k++) exp_q.push_back(w_zero());
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      vec_cnt++;
      if (obs !== exp_q[i]) begin
        $display("FAIL halt cyc%0d: got %h want %h", i, obs, exp_q[i]); miss_cnt++;
      end
      @(negedge clk);
    end
    start = 1'b1; @(negedge clk); start = 1'b0;
    vec_cnt++;
    if (obs !== w_t0()) begin
      $display("FAIL halt_resume: got %h want %h", obs, w_t0()); miss_cnt++;
    end
  endtask

  task automatic test_illegal();
    do_clear(); ir = IR_BAD;
    push_fetch();
    exp_q.push_back(w(19'd0, 5'd0, 1'b1, 1'b0));
    exp_q.push_back(w(19'd0, 5'd0, 1'b0, 1'b1));
    exp_q.push_back(w(19'd0, 5'd0, 1'b0, 1'b1));
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      vec_cnt++;
      if (obs !== exp_q[i]) begin
        $display("FAIL illegal cyc%0d: got %h want %h", i, obs, exp_q[i]); miss_cnt++;
      end
      @(negedge clk);
    end
    start = 1'b1; @(negedge clk); start = 1'b0;
    vec_cnt++;
    if (obs !== w_t0()) begin
      $display("FAIL illegal_cleared_by_start: got %h want %h", obs, w_t0()); miss_cnt++;
    end
  endtask

  // ADD immediately followed by NOT; ir changes during the second T0.
  task automatic test_back_to_back();
    do_clear(); ir = IR_ADD;
    push_fetch();
    exp_q.push_back(w(S_GRB | S_ROUT | S_YIN, 5'd0, 1'b1, 1'b0));
    exp_q.push_back(w(S_GRC | S_ROUT | S_ZIN, 5'd3, 1'b1, 1'b0));
    exp_q.push_back(w(S_ZLO | S_GRA | S_RIN, 5'd0, 1'b1, 1'b0));
    exp_q.push_back(w_t0()); exp_q.push_back(w_t1()); exp_q.push_back(w_t2());
    exp_q.push_back(w(S_GRB | S_ROUT | S_ZIN, 5'd18, 1'b1, 1'b0));
    exp_q.push_back(w(S_ZLO | S_GRA | S_RIN, 5'd0, 1'b1, 1'b0));
    exp_q.push_back(w_t0());
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      vec_cnt++;
      if (obs !== exp_q[i]) begin
        $display("FAIL b2b cyc%0d: got %h want %h", i, obs, exp_q[i]); miss_cnt++;
      end
      if (i == 6) ir = IR_NOT;
      @(negedge clk);
    end
  endtask

  initial begin
    start = 1'b0; clr = 1'b1; ir = 32'd0;
    test_reset();
    test_add();
    test_not();
    test_mul();
    test_nop_start_ignored();
    test_halt();
    test_illegal();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 32-bit bus-based datapath. It drives the datapath's one-hot transfer and load strobes through the fetch states T0–T2 and the register-to-register ALU execute states. It takes the instruction word from the datapath IR and replaces the hand-driven control stimulus in datapath benches with a clocked Moore FSM. It sits directly upstream of the datapath's control inputs.

## Interface
- No parameters. Opcode values and state encodings are constants in the shared package.
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins or resumes sequencing from IDLE or HALT.
- ir  in  32  instruction word from the datapath IR.
  - Fields: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
- PCout, Zlowout, ZHighout, MDRout  out  1  bus-source strobes.
- MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1  register-load strobes.
  - Zin drives the datapath's ZHIin and ZLOin together.
- IncPC, Read  out  1  PC-increment and memory-read strobes.
- Gra, Grb, Grc, Rin, Rout  out  1  register-select and encode strobes.
- operation  out  5  ALU opcode.
- run  out  1  high in T0–T6.
- illegal  out  1  sticky; set by an undefined opcode, cleared by clr or start.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. Each state lasts one cycle.
- Outputs are Moore, decoded from the state and ir[31:27] only. Any strobe not listed for a state is 0.
- IDLE:
  - All outputs 0.
  - start → T0; otherwise stay in IDLE.
- Fetch states:
  - T0: PCout, MARin, IncPC, Zin → T1.
  - T1: Zlowout, PCin, Read, MDRin → T2.
  - T2: MDRout, IRin → T3. IR is valid from T3 onward.
- Opcode classes, decoded in T3:
  - Binary: ADD 3, SUB 4, SHR 5, SHRA 6, SHL 7, ROR 8, ROL 9, AND 10, OR 11.
  - Unary: NEG 17, NOT 18.
  - MULDIV: MUL 15, DIV 16.
  - NOP 26.
  - HALT 27.
  - Any other value is illegal.
- Binary sequence:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, operation = opcode.
  - T5: Zlowout, Gra, Rin → T0.
- Unary sequence:
  - T3: Grb, Rout, Zin, operation = opcode.
  - T4: Zlowout, Gra, Rin → T0.
- MULDIV sequence:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, operation = opcode.
  - T5: Zlowout, LOin.
  - T6: ZHighout, HIin → T0.
- NOP: T3 drives no strobes → T0.
- HALT: T3 → HALT.
- Illegal opcode: T3 sets illegal → HALT.
- HALT state:
  - All strobes 0, run = 0.
  - start → T0 and clears illegal. The PC was already incremented in T0, so execution resumes at the next word.
- start outside IDLE and HALT is ignored.
- operation is 0 whenever it is not listed for the current state.

## Timing
- Reset:
  - clr asserts asynchronously: state = IDLE, every output 0, illegal = 0, including in the middle of an instruction.
  - clr deasserting followed by start at edge n → T0 at edge n+1.
- Cycles per instruction, counted from T0 entry to the next T0 entry:
  - NOP: 4.
  - Unary: 5.
  - Binary: 6.
  - MULDIV: 7.
- clr and start asserted in the same cycle: clr wins and the block stays in IDLE.
- Outputs are registered-state decodes and stay stable for the whole cycle. The datapath samples load strobes at the next rising edge.

## Configuration
- MUL_DIV_EN defined:
  - MUL and DIV follow the MULDIV sequence.
  - HIin, LOin and ZHighout are driven as specified.
- MUL_DIV_EN undefined:
  - Opcodes 15 and 16 decode as illegal and go to HALT.
  - T6 is removed.
  - HIin, LOin and ZHighout are tied to 0.

## Structure
- Package control_defs holds:
  - opcode constants (OP_ADD … OP_HALT);
  - state encoding constants (4-bit, IDLE = 0);
  - opcode-class codes (CLS_BINARY, CLS_UNARY, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILLEGAL).
- Sub-module op_classifier: combinational map from the 5-bit opcode to its class, instantiated once.
- Top level: state register, next-state logic, output decode.

## Test plan
- Reset: clr = 1 during T2 of a fetch → state IDLE immediately, all outputs 0, run = 0.
- ADD: start, then ir = 0x18918000 (add R1,R2,R3).
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, operation = 3.
  - T5: Gra, Rin, Zlowout.
  - Next T0 exactly 6 cycles after the first T0.
- NOT: ir = 0x90900000 (not R1,R2).
  - T3: Grb, Rout, Zin, operation = 18.
  - T4: Gra, Rin.
  - 5-cycle instruction.
- MUL: ir = 0x78118000.
  - With MUL_DIV_EN: T5 LOin with Zlowout, T6 HIin with ZHighout, 7 cycles.
  - Without MUL_DIV_EN: illegal = 1, HALT after T3.
- HALT: ir = 0xD8000000 → HALT after T3, run = 0. Strobes stay 0 for 20 cycles with no start; start → T0 next edge.
- Illegal: ir = 0xF8000000 → illegal = 1 and HALT. Next start clears illegal.
